io_mapper_seq: RTL
==================

// Module: io_mapper_seq
// PURPOSE
//  Registered, parametrised successor to the PAL address decoders on the Konami
//  I/O mapper boards. Decodes the CPU address into NREG active-low chip selects
//  using per-region base/mask, wait-state and WOCO qualification. Holds the
//  bank/WOCO control latch internally. Sequences each access IDLE->WAIT->ACK,
//  so downstream memories see glitch-free selects plus a ready strobe.
// PARAMETERS
//  ADDR_W      16                   CPU address width
//  NREG        8                    number of decoded regions / chip selects
//  BANK_W      5                    width of bank latch field
//  CTRL_ADDR   16'h5F88             write address of bank/WOCO control latch
//  REG_BASE    {NREG*ADDR_W}        packed base addresses, region i at [i*ADDR_W +: ADDR_W]
//  REG_MASK    {NREG*ADDR_W}        packed compare masks (1 = bit compared)
//  REG_WAIT    {NREG*3}             packed wait states 0..7 per region
//  REG_COND    {NREG*2}             2'b00 always, 2'b01 only WOCO=1, 2'b10 only WOCO=0, 2'b11 disabled
// PORTS
//  clk       in   1        system clock
//  rst       in   1        asynchronous active-high reset
//  as_n      in   1        CPU address strobe, active low
//  rw        in   1        1 = read, 0 = write
//  addr      in   ADDR_W   CPU address
//  din       in   8        CPU write data (control latch only)
//  init      in   1        board INIT; low forces all cs_n high, FSM held in IDLE
//  cs_n      out  NREG     registered chip selects, active low
//  ready     out  1        one-cycle access-complete strobe
//  bank      out  BANK_W   latched bank number (din[BANK_W-1:0])
//  woco      out  1        latched work/colour select (din[7])
//  unmapped  out  1        sticky flag: an access hit no region; cleared by rst only
// BEHAVIOUR
//  Reset (async, rst=1): cs_n all ones, ready=0, bank=0, woco=0, unmapped=0, FSM=IDLE.
//  Region i hits when ((addr ^ base_i) & mask_i)==0 and REG_COND_i is met by the current woco.
//  Priority: the lowest hitting index wins. At most one cs_n bit is low at any time.
//  FSM:
//   IDLE: as_n sampled low and init=1 -> decode addr; latch winner index and its wait count W.
//         Winner found: drive its cs_n low next cycle, go WAIT.
//         No winner: set unmapped, go ACK, no cs_n asserted.
//   WAIT: hold cs_n; count down W; at 0 -> ACK. W=0 means ACK the very next cycle.
//   ACK:  ready=1 for exactly one cycle; cs_n stays low; go HOLD.
//   HOLD: cs_n stays low until as_n high; then cs_n all high, go IDLE.
//         The next access cannot start the same cycle as_n rises.
//  Latency, as_n low to ready: 2+W cycles (mapped), 2 cycles (unmapped).
//  Abort: as_n high in WAIT or ACK -> cs_n released, no ready, go IDLE next cycle.
//  Control latch: write (rw=0) to exactly CTRL_ADDR is captured on entering ACK.
//   The latch updates bank and woco. The access decodes like any other; CTRL_ADDR may also hit a region.
//  Decode uses woco as it stood at IDLE sampling, so a latch write affects only later accesses.
//  init low mid-access -> cs_n released next cycle, no ready, FSM to IDLE; bank/woco retained.
//  rst mid-access: immediate return to reset values regardless of state.
//  Wait counter is 3 bits and never wraps: it loads once per access and saturates at 0.
// STRUCTURE
//  Package io_mapper_pkg: FSM state encoding (IDLE/WAIT/ACK/HOLD) and REG_COND codes.
//  It also holds the default Aliens map constants.
//  Sub-module io_region_match: combinational per-region compare plus priority encoder.
//   Outputs are the hit flag, winner index and wait count. Instantiated once.
//  Top: FSM, wait counter, control latch, registered cs_n/ready/unmapped.
// TESTING
//  1 Region 0 base 8000 mask 8000 wait 0: read 9000 -> cs_n=FE in cycle 1, ready pulses in cycle 2.
//  2 Region 1 wait 3: read 6000 -> ready in cycle 5; cs_n[1] low until as_n rises, then FF.
//  3 Write din=8'h85 to 5F88 -> bank=5, woco=1.
//    Then read 0100: region 2 (cond 01) is selected, not region 3 (cond 10).
//  4 Overlap check: regions 2 and 3 both always-enabled at 0000 -> only cs_n[2] low (priority).
//  5 Read 4000 with no region mapped -> no cs_n low, ready after 2 cycles, unmapped=1 and sticky.
//  6 Abort and reset: as_n high during WAIT -> no ready, cs_n=FF next cycle.
//    rst pulse in HOLD -> all outputs at reset values immediately.

Source files
------------

// File: rtl/io_mapper_pkg.sv
// Shared definitions for the I/O mapper: FSM encoding, region condition codes
// and the default Aliens board address map.
package io_mapper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Region qualification against the WOCO latch
    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_WOCO1  = 2'b01;
    localparam logic [1:0] COND_WOCO0  = 2'b10;
    localparam logic [1:0] COND_OFF    = 2'b11;

    // Default Aliens map, region i at slice i (region 0 is the rightmost entry).
    //  r0 8000-FFFF ROM,  r1 6000-7FFF slow I/O (3 waits),
    //  r2 0000-0FFF work RAM (WOCO=1), r3 0000-0FFF colour RAM (WOCO=0),
    //  r4 5F80-5F8F control block (shares the latch address), r5-r7 unused.
    localparam logic [8*16-1:0] ALIENS_BASE = {
        16'h0000, 16'h0000, 16'h0000, 16'h5F80,
        16'h0000, 16'h0000, 16'h6000, 16'h8000
    };
    localparam logic [8*16-1:0] ALIENS_MASK = {
        16'h0000, 16'h0000, 16'h0000, 16'hFFF0,
        16'hF000, 16'hF000, 16'hE000, 16'h8000
    };
    localparam logic [8*3-1:0] ALIENS_WAIT = {
        3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd1, 3'd3, 3'd0
    };
    localparam logic [8*2-1:0] ALIENS_COND = {
        COND_OFF, COND_OFF, COND_OFF, COND_ALWAYS,
        COND_WOCO0, COND_WOCO1, COND_ALWAYS, COND_ALWAYS
    };

    // True when a region's condition code allows it under the given WOCO value
    function automatic logic cond_met(input logic [1:0] cond, input logic woco);
        case (cond)
            COND_ALWAYS: cond_met = 1'b1;
            COND_WOCO1:  cond_met = woco;
            COND_WOCO0:  cond_met = ~woco;
            default:     cond_met = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/io_region_match.sv
// Combinational region decode: per-region base/mask compare qualified by WOCO,
// followed by a priority encoder where the lowest hitting index wins.
module io_region_match
    import io_mapper_pkg::*;
#(
    parameter int                     ADDR_W   = 16,
    parameter int                     NREG     = 8,
    parameter int                     IDX_W    = (NREG > 1) ? $clog2(NREG) : 1,
    parameter logic [NREG*ADDR_W-1:0] REG_BASE = ALIENS_BASE,
    parameter logic [NREG*ADDR_W-1:0] REG_MASK = ALIENS_MASK,
    parameter logic [NREG*3-1:0]      REG_WAIT = ALIENS_WAIT,
    parameter logic [NREG*2-1:0]      REG_COND = ALIENS_COND
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              woco,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic [2:0]        wait_cnt
);

    // Scan from the highest index down so the lowest hitting region overwrites last
    always_comb begin
        hit      = 1'b0;
        idx      = '0;
        wait_cnt = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((((addr ^ REG_BASE[i*ADDR_W +: ADDR_W]) & REG_MASK[i*ADDR_W +: ADDR_W]) == '0)
                && cond_met(REG_COND[i*2 +: 2], woco)) begin
                hit      = 1'b1;
                idx      = IDX_W'(i);
                wait_cnt = REG_WAIT[i*3 +: 3];
            end
        end
    end

endmodule

// File: rtl/io_mapper_seq.sv
// Registered I/O address mapper: decodes CPU accesses into one-hot active-low
// chip selects, sequences IDLE->WAIT->ACK->HOLD with per-region wait states,
// and owns the bank/WOCO control latch.
module io_mapper_seq
    import io_mapper_pkg::*;
#(
    parameter int                     ADDR_W    = 16,
    parameter int                     NREG      = 8,
    parameter int                     BANK_W    = 5,
    parameter logic [ADDR_W-1:0]      CTRL_ADDR = 16'h5F88,
    parameter logic [NREG*ADDR_W-1:0] REG_BASE  = ALIENS_BASE,
    parameter logic [NREG*ADDR_W-1:0] REG_MASK  = ALIENS_MASK,
    parameter logic [NREG*3-1:0]      REG_WAIT  = ALIENS_WAIT,
    parameter logic [NREG*2-1:0]      REG_COND  = ALIENS_COND
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              as_n,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    input  logic              init,
    output logic [NREG-1:0]   cs_n,
    output logic              ready,
    output logic [BANK_W-1:0] bank,
    output logic              woco,
    output logic              unmapped
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [NREG-1:0]   cs_n_q, cs_n_d;
    logic              ready_q, ready_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              woco_q, woco_d;
    logic              unmapped_q, unmapped_d;
    logic              ctrl_wr_q, ctrl_wr_d;

    logic              win_hit;
    logic [IDX_W-1:0]  win_idx;
    logic [2:0]        win_wait;
    logic              unused_din;

    // Only the bank field and bit 7 of the write data reach the latch
    assign unused_din = ^din;

    io_region_match #(
        .ADDR_W   (ADDR_W),
        .NREG     (NREG),
        .IDX_W    (IDX_W),
        .REG_BASE (REG_BASE),
        .REG_MASK (REG_MASK),
        .REG_WAIT (REG_WAIT),
        .REG_COND (REG_COND)
    ) u_match (
        .addr     (addr),
        .woco     (woco_q),
        .hit      (win_hit),
        .idx      (win_idx),
        .wait_cnt (win_wait)
    );

    // Next-state logic for the access sequencer, wait counter and latch
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cs_n_d     = cs_n_q;
        ready_d    = 1'b0;
        bank_d     = bank_q;
        woco_d     = woco_q;
        unmapped_d = unmapped_q;
        ctrl_wr_d  = ctrl_wr_q;

        case (state_q)
            ST_IDLE: begin
                cs_n_d = '1;
                if (!as_n && init) begin
                    ctrl_wr_d = !rw && (addr == CTRL_ADDR);
                    if (win_hit) begin
                        cs_n_d[win_idx] = 1'b0;
                        cnt_d           = win_wait;
                        state_d         = ST_WAIT;
                    end else begin
                        // Unmapped: no select; ACK spends an extra cycle so
                        // ready lands two cycles after the strobe
                        unmapped_d = 1'b1;
                        state_d    = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (as_n) begin
                    cs_n_d  = '1;
                    state_d = ST_IDLE;
                end else if (cnt_q == 3'd0) begin
                    ready_d = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACK: begin
                if (as_n) begin
                    cs_n_d  = '1;
                    state_d = ST_IDLE;
                end else if (!ready_q) begin
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                if (as_n) begin
                    cs_n_d  = '1;
                    state_d = ST_IDLE;
                end
            end
        endcase

        // INIT low drops any access in progress; the latch keeps its contents
        if (!init) begin
            cs_n_d  = '1;
            ready_d = 1'b0;
            state_d = ST_IDLE;
        end

        // The latch write completes together with the ready strobe
        if (ready_d && ctrl_wr_q) begin
            bank_d = din[BANK_W-1:0];
            woco_d = din[7];
        end
    end

    // State and output registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cs_n_q     <= '1;
            ready_q    <= 1'b0;
            bank_q     <= '0;
            woco_q     <= 1'b0;
            unmapped_q <= 1'b0;
            ctrl_wr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cs_n_q     <= cs_n_d;
            ready_q    <= ready_d;
            bank_q     <= bank_d;
            woco_q     <= woco_d;
            unmapped_q <= unmapped_d;
            ctrl_wr_q  <= ctrl_wr_d;
        end
    end

    assign cs_n     = cs_n_q;
    assign ready    = ready_q;
    assign bank     = bank_q;
    assign woco     = woco_q;
    assign unmapped = unmapped_q;

endmodule
